// File: rtl/reg_bank_atomic.sv
// reg_bank_atomic: byte-addressed RW register bank with atomic multi-byte commit, lock/err control and status snapshot
module reg_bank_atomic #(
  parameter int pBYTECNT_SIZE = 7,
  parameter logic [7:0] pADDR_BASE = 8'h60,
  parameter int pNUM_REGS = 4,
  parameter int pREG_BYTES = 4,
  parameter logic [pNUM_REGS*pREG_BYTES*8-1:0] pRESET_VALUE = '0
) (
  input  logic clk_usb,
  input  logic reset_n,
  input  logic [7:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0] reg_datai,
  output logic [7:0] reg_datao,
  input  logic reg_read,
  input  logic reg_write,
  input  logic [pREG_BYTES*8-1:0] status_i,
  output logic [pNUM_REGS*pREG_BYTES*8-1:0] regs_o,
  output logic [pNUM_REGS-1:0] update_o
);
  localparam int rw = pREG_BYTES * 8;
  localparam int iw = pNUM_REGS > 1 ? $clog2(pNUM_REGS) : 1;
  localparam int bw = pREG_BYTES > 1 ? $clog2(pREG_BYTES) : 1;
  localparam logic [8:0] nregs = 9'(pNUM_REGS);
  localparam logic [pBYTECNT_SIZE-1:0] nbytes = pBYTECNT_SIZE'(pREG_BYTES);
  localparam logic [pBYTECNT_SIZE-1:0] last = pBYTECNT_SIZE'(pREG_BYTES - 1);
  typedef enum logic {IDLE, STAGING} state_t;
  state_t state, state_nx;
  logic [rw-1:0] regs [pNUM_REGS];
  logic [rw-1:0] stg, snap, stg_mod;
  logic [iw-1:0] stg_idx, idx;
  logic [bw-1:0] bsel;
  logic [8:0] off;
  logic [7:0] rd_byte;
  logic lock, err;
  logic rw_hit, ctrl_hit, stat_hit, ctrl_wr, in_rng, bc0, wr_rw, own, start, mid, commit, err_set;
  // nine-bit offset so addresses below the base wrap far out of range instead of aliasing
  assign off = {1'b0, reg_address} - {1'b0, pADDR_BASE};
  assign idx = off[iw-1:0];
  assign bsel = reg_bytecnt[bw-1:0];
  assign rw_hit = off < nregs;
  assign ctrl_hit = off == nregs;
  assign stat_hit = off == nregs + 9'd1;
  assign ctrl_wr = reg_write && ctrl_hit;
  assign in_rng = reg_bytecnt < nbytes;
  assign bc0 = reg_bytecnt == '0;
  assign wr_rw = reg_write && rw_hit && !lock && in_rng;
  assign own = state == STAGING && stg_idx == idx;
  assign start = wr_rw && bc0;
  assign mid = wr_rw && !bc0 && own;
  assign commit = wr_rw && reg_bytecnt == last && (bc0 || own);
  assign err_set = wr_rw && !bc0 && !own;
  // a byte-0 write reseeds from the committed value; later bytes patch the staging buffer
  always_comb begin
    stg_mod = bc0 ? regs[idx] : stg;
    stg_mod[{bsel, 3'b000} +: 8] = reg_datai;
  end
  always_comb begin
    state_nx = (lock || commit) ? IDLE : start ? STAGING : state;
    rd_byte = (rw_hit && in_rng) ? regs[idx][{bsel, 3'b000} +: 8] :
              ctrl_hit ? {6'b0, err, lock} :
              (stat_hit && bc0) ? status_i[7:0] :
              (stat_hit && in_rng) ? snap[{bsel, 3'b000} +: 8] : 8'h00;
  end
  always_ff @(posedge clk_usb)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_usb)
    if (!reset_n) begin
      for (int k = 0; k < pNUM_REGS; k++) regs[k] <= pRESET_VALUE[k*rw +: rw];
      stg <= '0;
      stg_idx <= '0;
      snap <= '0;
      lock <= 1'b0;
      err <= 1'b0;
      update_o <= '0;
      reg_datao <= '0;
    end else begin
      if (start || mid) stg <= stg_mod;
      if (start) stg_idx <= idx;
      if (commit) regs[idx] <= stg_mod;
      update_o <= commit ? pNUM_REGS'(1) << idx : '0;
      if (ctrl_wr) lock <= reg_datai[0];
      err <= err_set || (err && !(ctrl_wr && reg_datai[1]));
      if (reg_read && stat_hit && bc0) snap <= status_i;
      reg_datao <= reg_read ? rd_byte : 8'h00;
    end
  for (genvar i = 0; i < pNUM_REGS; i++) begin : g_out
    assign regs_o[i*rw +: rw] = regs[i];
  end
endmodule

// File: tb/tb_reg_bank_atomic.sv
// tb_reg_bank_atomic: vector table, hand-written reset corner and randomized run against a byte-array model
module tb_reg_bank_atomic;
  localparam logic [127:0] rv  = 128'hD0D1D2D3_C0C1C2C3_B0B1B2B3_A0A1A2A3;
  localparam logic [127:0] rv1 = 128'hD0D1D2D3_C0C1C2C3_44332211_A0A1A2A3;
  localparam logic [127:0] rv2 = 128'hD0D1D2D3_AA998877_44332211_A0A1A2A3;
  localparam logic [127:0] rv3 = 128'hD0D1D2D3_AA998877_44332211_04030201;
  logic clk_usb = 0, reset_n = 0;
  logic [7:0] reg_address = 0, reg_datai = 0, reg_datao;
  logic [6:0] reg_bytecnt = 0;
  logic reg_read = 0, reg_write = 0;
  logic [31:0] status_i = 0;
  logic [127:0] regs_o;
  logic [3:0] update_o;
  int total = 0, bad = 0;
  always #5 clk_usb = ~clk_usb;
  reg_bank_atomic #(.pRESET_VALUE(rv)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datai(reg_datai), .reg_datao(reg_datao), .reg_read(reg_read), .reg_write(reg_write),
    .status_i(status_i), .regs_o(regs_o), .update_o(update_o));
  typedef struct packed {
    logic wr; logic rd; logic [7:0] a; logic [6:0] bc; logic [7:0] d; logic [31:0] st;
    logic [7:0] ed; logic [3:0] eu; logic [127:0] er;
  } vec_t;
  vec_t vecs[$];
  logic [7:0] mr [4][4];
  logic [7:0] mstg [4];
  logic [7:0] msnap [4];
  bit mst, mlock, merr;
  int midx;
  function automatic vec_t v(input logic wr, rd, input logic [7:0] a, input logic [6:0] bc,
                             input logic [7:0] d, input logic [31:0] st, input logic [7:0] ed,
                             input logic [3:0] eu, input logic [127:0] er);
    return '{wr: wr, rd: rd, a: a, bc: bc, d: d, st: st, ed: ed, eu: eu, er: er};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic wr, rd, input logic [7:0] a, input logic [6:0] bc,
                       input logic [7:0] d, input logic [31:0] st);
    reg_write = wr; reg_read = rd; reg_address = a; reg_bytecnt = bc; reg_datai = d; status_i = st;
    @(posedge clk_usb); #1;
    reg_write = 0; reg_read = 0;
  endtask
  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) mr[r][b] = rv[r*32 + b*8 +: 8];
    for (int b = 0; b < 4; b++) begin mstg[b] = 0; msnap[b] = 0; end
    mst = 0; mlock = 0; merr = 0; midx = 0;
  endtask
  task automatic do_reset();
    reset_n = 0;
    @(posedge clk_usb); #1;
    reset_n = 1;
    model_reset();
  endtask
  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) f[r*32 + b*8 +: 8] = mr[r][b];
    return f;
  endfunction
  // one clock edge of the register bank described directly from its byte-level rules
  task automatic model_step(input logic wr, rd, input logic [7:0] a, input int bc,
                            input logic [7:0] d, input logic [31:0] st,
                            output logic [7:0] ed, output logic [3:0] eu);
    int off;
    bit es;
    off = int'(a) - 96;
    ed = 0; eu = 0; es = 0;
    if (rd) begin
      if (off >= 0 && off < 4) ed = bc < 4 ? mr[off][bc] : 8'h00;
      else if (off == 4) ed = {6'b0, merr, mlock};
      else if (off == 5) ed = bc == 0 ? st[7:0] : bc < 4 ? msnap[bc] : 8'h00;
    end
    if (wr && off >= 0 && off < 4 && !mlock && bc < 4) begin
      if (bc == 0) begin
        for (int b = 0; b < 4; b++) mstg[b] = mr[off][b];
        mstg[0] = d; mst = 1; midx = off;
      end else if (mst && midx == off) begin
        mstg[bc] = d;
        if (bc == 3) begin
          for (int b = 0; b < 4; b++) mr[off][b] = mstg[b];
          eu = 4'(1 << off); mst = 0;
        end
      end else es = 1;
    end
    if (rd && off == 5 && bc == 0)
      for (int b = 0; b < 4; b++) msnap[b] = st[b*8 +: 8];
    if (mlock) mst = 0;
    if (wr && off == 4) begin
      mlock = d[0];
      if (d[1]) merr = 0;
    end
    if (es) merr = 1;
  endtask
  task automatic rand_op(input logic wr, rd, input logic [7:0] a, input logic [6:0] bc,
                         input logic [7:0] d, input int n);
    logic [7:0] ed;
    logic [3:0] eu;
    logic [31:0] st;
    st = $urandom;
    model_step(wr, rd, a, int'(bc), d, st, ed, eu);
    drive(wr, rd, a, bc, d, st);
    chk($sformatf("rnd%0d datao", n), {120'b0, reg_datao}, {120'b0, ed});
    chk($sformatf("rnd%0d update", n), {124'b0, update_o}, {124'b0, eu});
    chk($sformatf("rnd%0d regs", n), regs_o, model_flat());
  endtask
  initial begin
    vecs.push_back(v(1,0,8'h61,0,8'h11,0,8'h00,4'h0,rv));
    vecs.push_back(v(1,0,8'h61,1,8'h22,0,8'h00,4'h0,rv));
    vecs.push_back(v(1,0,8'h61,2,8'h33,0,8'h00,4'h0,rv));
    vecs.push_back(v(1,0,8'h61,3,8'h44,0,8'h00,4'h2,rv1));
    vecs.push_back(v(0,0,8'h61,0,8'h00,0,8'h00,4'h0,rv1));
    vecs.push_back(v(0,1,8'h61,3,8'h00,0,8'h44,4'h0,rv1));
    vecs.push_back(v(0,1,8'h61,0,8'h00,0,8'h11,4'h0,rv1));
    vecs.push_back(v(0,1,8'h60,0,8'h00,0,8'hA3,4'h0,rv1));
    vecs.push_back(v(1,0,8'h60,0,8'h55,0,8'h00,4'h0,rv1));
    vecs.push_back(v(1,0,8'h60,1,8'h66,0,8'h00,4'h0,rv1));
    vecs.push_back(v(1,0,8'h62,0,8'h77,0,8'h00,4'h0,rv1));
    vecs.push_back(v(0,1,8'h60,1,8'h00,0,8'hA2,4'h0,rv1));
    vecs.push_back(v(1,0,8'h62,1,8'h88,0,8'h00,4'h0,rv1));
    vecs.push_back(v(1,0,8'h62,2,8'h99,0,8'h00,4'h0,rv1));
    vecs.push_back(v(1,0,8'h62,3,8'hAA,0,8'h00,4'h4,rv2));
    vecs.push_back(v(0,1,8'h64,0,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h60,2,8'h01,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h64,0,8'h00,0,8'h02,4'h0,rv2));
    vecs.push_back(v(1,0,8'h64,0,8'h02,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h64,0,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h64,0,8'h01,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h64,0,8'h00,0,8'h01,4'h0,rv2));
    vecs.push_back(v(1,0,8'h63,0,8'h05,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h63,1,8'h06,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h63,2,8'h07,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h63,3,8'h08,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h63,0,8'h00,0,8'hD3,4'h0,rv2));
    vecs.push_back(v(0,1,8'h64,0,8'h00,0,8'h01,4'h0,rv2));
    vecs.push_back(v(1,0,8'h64,0,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h65,0,8'h00,32'hAABBCCDD,8'hDD,4'h0,rv2));
    vecs.push_back(v(0,1,8'h65,1,8'h00,0,8'hCC,4'h0,rv2));
    vecs.push_back(v(0,1,8'h65,2,8'h00,0,8'hBB,4'h0,rv2));
    vecs.push_back(v(0,1,8'h65,3,8'h00,0,8'hAA,4'h0,rv2));
    vecs.push_back(v(0,1,8'h65,4,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h61,4,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h66,0,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h61,5,8'hFF,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h61,4,8'hEE,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h64,0,8'h00,0,8'h00,4'h0,rv2));
    vecs.push_back(v(0,1,8'h61,0,8'h00,0,8'h11,4'h0,rv2));
    vecs.push_back(v(1,0,8'h60,0,8'h01,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h60,1,8'h02,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,0,8'h60,2,8'h03,0,8'h00,4'h0,rv2));
    vecs.push_back(v(1,1,8'h60,3,8'h04,0,8'hA0,4'h1,rv3));
    vecs.push_back(v(0,1,8'h60,3,8'h00,0,8'h04,4'h0,rv3));
    repeat (2) @(posedge clk_usb);
    #1;
    drive(0, 1, 8'h61, 0, 8'h00, 0);
    chk("reset regs", regs_o, rv);
    chk("reset update", {124'b0, update_o}, 128'h0);
    chk("reset datao", {120'b0, reg_datao}, 128'h0);
    reset_n = 1;
    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].bc, vecs[i].d, vecs[i].st);
      chk($sformatf("vec%0d datao", i), {120'b0, reg_datao}, {120'b0, vecs[i].ed});
      chk($sformatf("vec%0d update", i), {124'b0, update_o}, {124'b0, vecs[i].eu});
      chk($sformatf("vec%0d regs", i), regs_o, vecs[i].er);
    end
    do_reset();
    drive(1, 0, 8'h62, 0, 8'h12, 0);
    drive(1, 0, 8'h62, 1, 8'h34, 0);
    reset_n = 0;
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    chk("mid-stage reset regs", regs_o, rv);
    reset_n = 1;
    drive(1, 0, 8'h62, 2, 8'h56, 0);
    chk("post-reset byte2 update", {124'b0, update_o}, 128'h0);
    drive(1, 0, 8'h62, 3, 8'h78, 0);
    chk("post-reset byte3 update", {124'b0, update_o}, 128'h0);
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    chk("post-reset idle update", {124'b0, update_o}, 128'h0);
    chk("post-reset regs", regs_o, rv);
    drive(0, 1, 8'h64, 0, 8'h00, 0);
    chk("post-reset err", {120'b0, reg_datao}, 128'h02);
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if ($urandom % 3 == 0) begin
        logic [7:0] a;
        a = 8'h60 + 8'($urandom_range(0, 3));
        for (int b = 0; b < 4; b++)
          rand_op(1, 1'($urandom % 2), a, 7'(b), 8'($urandom), n * 10 + b);
      end else begin
        logic [7:0] a, d;
        a = ($urandom % 16 == 0) ? 8'($urandom) : 8'h60 + 8'($urandom_range(0, 7));
        d = 8'($urandom);
        if (a == 8'h64 && $urandom % 4 != 0) d[0] = 1'b0;
        rand_op(1'($urandom % 2), 1'($urandom % 2), a, 7'($urandom_range(0, 5)), d, n * 10 + 9);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
